soc_line_dma_writer: RTL

- Avalon-MM burst write master that stores one scan line of 32-bit pixel words in SDRAM.
- Takes the line buffer base address from the DMA-address PIO output (out_port -> base_addr).
- Takes pixel words from the line-capture stream on an Avalon-ST sink.
- Software arms the block with a start pulse; the block reports busy/done and a count of completed lines.

---
 rtl/soc_line_dma_writer_pkg.sv | 18 +
 rtl/soc_line_dma_fifo.sv | 61 ++++++
 rtl/soc_line_dma_writer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/soc_line_dma_writer_pkg.sv
// rtl/soc_line_dma_writer_pkg.sv - shared state encodings and constants for the line DMA writer
package soc_line_dma_writer_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_BURST = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Word index to byte offset
    localparam int WORD_SHIFT = 2;

    localparam int DEFAULT_BURST_LEN  = 16;
    localparam int DEFAULT_FIFO_DEPTH = 64;

endpackage

// File: rtl/soc_line_dma_fifo.sv
// rtl/soc_line_dma_fifo.sv - synchronous show-ahead FIFO between the pixel sink and the burst master
module soc_line_dma_fifo
    import soc_line_dma_writer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = DEFAULT_FIFO_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic [AW:0]       count_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    // Head word is visible without a read strobe
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage array; contents need no reset because the pointers gate visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy; push and pop in the same cycle leave the count unchanged
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/soc_line_dma_writer.sv
// rtl/soc_line_dma_writer.sv - Avalon-MM burst writer storing one scan line of pixel words
module soc_line_dma_writer
    import soc_line_dma_writer_pkg::*;
#(
    parameter int BURST_LEN  = DEFAULT_BURST_LEN,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int BC_W       = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      base_addr,
    input  logic [LEN_W-1:0] line_words,
    input  logic             start,
    input  logic [31:0]      snk_data,
    input  logic             snk_valid,
    output logic             snk_ready,
    output logic [31:0]      avm_address,
    output logic             avm_write,
    output logic [31:0]      avm_writedata,
    output logic [BC_W-1:0]  avm_burstcount,
    input  logic             avm_waitrequest,
    output logic             busy,
    output logic             done,
    output logic [15:0]      line_cnt
);

    localparam int              CNT_W       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LEN_W-1:0] BURST_LEN_L = LEN_W'(BURST_LEN);
    localparam logic [LEN_W-1:0] ONE_L       = LEN_W'(1);

    state_e            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [LEN_W-1:0]  rem_in_q, rem_in_d;
    logic [LEN_W-1:0]  rem_out_q, rem_out_d;
    logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [31:0]       avm_address_q, avm_address_d;
    logic              avm_write_q, avm_write_d;
    logic [BC_W-1:0]   avm_burstcount_q, avm_burstcount_d;
    logic [15:0]       line_cnt_q, line_cnt_d;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [31:0]       fifo_head;
    logic              push;
    logic              beat_acc;
    logic [LEN_W-1:0]  bsz;

    assign busy           = (state_q == ST_FILL) || (state_q == ST_BURST);
    assign done           = (state_q == ST_DONE);
    assign snk_ready      = busy && !fifo_full && (rem_in_q != '0);
    assign push           = snk_valid && snk_ready;
    assign beat_acc       = avm_write_q && !avm_waitrequest;
    assign bsz            = (rem_out_q < BURST_LEN_L) ? rem_out_q : BURST_LEN_L;
    assign avm_address    = avm_address_q;
    assign avm_write      = avm_write_q;
    assign avm_burstcount = avm_burstcount_q;
    // Data bus reads zero outside bursts so it never exposes unreset FIFO storage
    assign avm_writedata  = avm_write_q ? fifo_head : '0;
    assign line_cnt       = line_cnt_q;

    soc_line_dma_fifo #(
        .DATA_W (32),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .wdata_i (snk_data),
        .pop_i   (beat_acc && !fifo_empty),
        .rdata_o (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Next-state and registered-output logic; bursts launch only when all their words are buffered
    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        rem_in_d         = push ? (rem_in_q - ONE_L) : rem_in_q;
        rem_out_d        = rem_out_q;
        beat_cnt_d       = beat_cnt_q;
        avm_address_d    = avm_address_q;
        avm_write_d      = avm_write_q;
        avm_burstcount_d = avm_burstcount_q;
        line_cnt_d       = line_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d    = base_addr & 32'hFFFF_FFFC;
                    rem_in_d  = line_words;
                    rem_out_d = line_words;
                    if (line_words == '0) begin
                        state_d    = ST_DONE;
                        line_cnt_d = line_cnt_q + 16'd1;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                if (LEN_W'(fifo_count) >= bsz) begin
                    state_d          = ST_BURST;
                    avm_write_d      = 1'b1;
                    avm_address_d    = addr_q;
                    avm_burstcount_d = bsz[BC_W-1:0];
                    beat_cnt_d       = bsz;
                end
            end
            ST_BURST: begin
                if (beat_acc) begin
                    beat_cnt_d = beat_cnt_q - ONE_L;
                    rem_out_d  = rem_out_q - ONE_L;
                    if (beat_cnt_q == ONE_L) begin
                        avm_write_d = 1'b0;
                        addr_d      = addr_q + (32'(avm_burstcount_q) << WORD_SHIFT);
                        if (rem_out_q == ONE_L) begin
                            state_d    = ST_DONE;
                            line_cnt_d = line_cnt_q + 16'd1;
                        end else begin
                            state_d = ST_FILL;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any burst in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_IDLE;
            addr_q           <= '0;
            rem_in_q         <= '0;
            rem_out_q        <= '0;
            beat_cnt_q       <= '0;
            avm_address_q    <= '0;
            avm_write_q      <= 1'b0;
            avm_burstcount_q <= '0;
            line_cnt_q       <= '0;
        end else begin
            state_q          <= state_d;
            addr_q           <= addr_d;
            rem_in_q         <= rem_in_d;
            rem_out_q        <= rem_out_d;
            beat_cnt_q       <= beat_cnt_d;
            avm_address_q    <= avm_address_d;
            avm_write_q      <= avm_write_d;
            avm_burstcount_q <= avm_burstcount_d;
            line_cnt_q       <= line_cnt_d;
        end
    end

endmodule
